// File: rtl/audio_channel_interleaver_pkg.sv
// Shared types and constants for the stereo PCM interleaver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: AUDIO_INTERLEAVER_SEQ_NUM_EN adds the SEQ header state.
package audio_interleaver_pkg;

`ifdef AUDIO_INTERLEAVER_SEQ_NUM_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_SEQ   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;
`endif

    // Upper half of the per-packet header word; lower half is the sequence number.
    localparam logic [15:0] SEQ_HDR    = 16'hA5A5;
    localparam int          DROP_CNT_W = 16;
    localparam int          AXIS_W     = 32;

endpackage

// File: rtl/audio_channel_interleaver_if.sv
// AXI-Stream word channel from the interleaver to the packetizer.
// Latency: n/a (wires only).
// Backpressure: tready from the slave; master holds tdata/tlast/tvalid while stalled.
// Signals: tdata[31:0], tvalid, tlast (master -> slave), tready (slave -> master).
interface audio_channel_interleaver_if;
    import audio_interleaver_pkg::*;

    logic [AXIS_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous frame FIFO with head and head+1 read ports for lookahead.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: writes refused when full unless a pop happens in the same cycle.
// Ports: clk/rst_n, wr_en_i/wr_dat_i, rd_en_i, rd_dat_o (head), rd_nxt_dat_o (head+1),
//        full_o, empty_o, count_o. DEPTH must be a power of two, at least 2.
module audio_frame_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic [WIDTH-1:0] rd_nxt_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // When full, the slot being written is the head being popped this cycle,
    // so accepting the write alongside a pop is safe.
    assign wr_ok = wr_en_i && (!full_o || rd_en_i);
    assign rd_ok = rd_en_i && !empty_o;

    assign rd_dat_o     = mem_q[rd_ptr_q];
    assign rd_nxt_dat_o = mem_q[rd_ptr_q + PTR_W'(1)];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_dat_i;
    end

endmodule

// File: rtl/audio_channel_interleaver.sv
// Buffers stereo PCM frames and emits them as sign-extended L,R words in fixed-size packets.
// Latency: left word 2 cycles after the strobe into an empty FIFO, right word one cycle later.
// Backpressure: AXI-Stream tready stalls output; input has none, frames arriving at a full FIFO are dropped and counted.
// Ports: ACLK, ARESETN (async active-low), s_left_data/s_right_data/s_sample_valid (frame input),
//        m_axis (stream master modport), overflow/overflow_clr/drop_count (sticky drop status).
// Optional feature macro: AUDIO_INTERLEAVER_SEQ_NUM_EN prefixes each packet with {16'hA5A5, seq}.
module audio_channel_interleaver
    import audio_interleaver_pkg::*;
#(
    parameter int SAMPLE_WIDTH      = 24,
    parameter int FRAMES_PER_PACKET = 32,
    parameter int FIFO_DEPTH        = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [SAMPLE_WIDTH-1:0]     s_left_data,
    input  logic [SAMPLE_WIDTH-1:0]     s_right_data,
    input  logic                        s_sample_valid,
    audio_channel_interleaver_if.master m_axis,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic [DROP_CNT_W-1:0]       drop_count
);
    localparam int FRAME_W = 2 * SAMPLE_WIDTH;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int FC_W    = (FRAMES_PER_PACKET > 1) ? $clog2(FRAMES_PER_PACKET) : 1;

    function automatic logic [AXIS_W-1:0] sext(input logic [SAMPLE_WIDTH-1:0] s);
        return AXIS_W'($signed(s));
    endfunction

    state_e                    state_q;
    logic [AXIS_W-1:0]         tdata_q;
    logic                      tvalid_q;
    logic                      tlast_q;
    logic [SAMPLE_WIDTH-1:0]   right_q;
    logic [FC_W-1:0]           frame_cnt_q;
    logic                      ovf_q, ovf_d;
    logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
`ifdef AUDIO_INTERLEAVER_SEQ_NUM_EN
    logic [15:0]               seq_q;
`endif

    logic [FRAME_W-1:0]        frame_in;
    logic [FRAME_W-1:0]        head_dat;
    logic [FRAME_W-1:0]        nxt_dat;
    logic [FRAME_W-1:0]        nxt_frame;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CNT_W-1:0]          fifo_cnt;
    logic                      hs;
    logic                      pop;
    logic                      wr_en;
    logic                      drop;
    logic                      more_after_pop;
    logic                      last_frame;

    assign frame_in   = {s_left_data, s_right_data};
    assign hs         = tvalid_q && m_axis.tready;
    // The head frame stays in the FIFO until its right word is taken.
    assign pop        = hs && (state_q == ST_RIGHT);
    assign wr_en      = s_sample_valid && (!fifo_full || pop);
    assign drop       = s_sample_valid && fifo_full && !pop;
    assign last_frame = (frame_cnt_q == FC_W'(FRAMES_PER_PACKET - 1));

    // After popping the head, the next frame is either already behind it in the
    // FIFO or is the one being written right now; picking it here keeps the
    // stream gap-free instead of detouring through IDLE.
    assign more_after_pop = (fifo_cnt > CNT_W'(1)) || wr_en;
    assign nxt_frame      = (fifo_cnt > CNT_W'(1)) ? nxt_dat : frame_in;

    audio_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (ACLK),
        .rst_n        (ARESETN),
        .wr_en_i      (wr_en),
        .wr_dat_i     (frame_in),
        .rd_en_i      (pop),
        .rd_dat_o     (head_dat),
        .rd_nxt_dat_o (nxt_dat),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_cnt)
    );

    // Clear wins over a drop in the same cycle.
    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (overflow_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Output FSM. The right sample is latched whenever a LEFT word is loaded so
    // the RIGHT word never depends on which source the frame came from.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            right_q     <= '0;
            frame_cnt_q <= '0;
`ifdef AUDIO_INTERLEAVER_SEQ_NUM_EN
            seq_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
`ifdef AUDIO_INTERLEAVER_SEQ_NUM_EN
                        if (frame_cnt_q == '0) begin
                            state_q <= ST_SEQ;
                            tdata_q <= {SEQ_HDR, seq_q};
                        end else begin
                            state_q <= ST_LEFT;
                            tdata_q <= sext(head_dat[FRAME_W-1:SAMPLE_WIDTH]);
                            right_q <= head_dat[SAMPLE_WIDTH-1:0];
                        end
`else
                        state_q <= ST_LEFT;
                        tdata_q <= sext(head_dat[FRAME_W-1:SAMPLE_WIDTH]);
                        right_q <= head_dat[SAMPLE_WIDTH-1:0];
`endif
                    end
                end
`ifdef AUDIO_INTERLEAVER_SEQ_NUM_EN
                ST_SEQ: begin
                    // The FIFO is guaranteed non-empty here and its head is frame 0.
                    if (hs) begin
                        state_q <= ST_LEFT;
                        tdata_q <= sext(head_dat[FRAME_W-1:SAMPLE_WIDTH]);
                        right_q <= head_dat[SAMPLE_WIDTH-1:0];
                        seq_q   <= seq_q + 16'd1;
                    end
                end
`endif
                ST_LEFT: begin
                    if (hs) begin
                        state_q <= ST_RIGHT;
                        tdata_q <= sext(right_q);
                        tlast_q <= last_frame;
                    end
                end
                ST_RIGHT: begin
                    if (hs) begin
                        tlast_q     <= 1'b0;
                        frame_cnt_q <= last_frame ? '0 : frame_cnt_q + FC_W'(1);
                        if (more_after_pop) begin
`ifdef AUDIO_INTERLEAVER_SEQ_NUM_EN
                            if (last_frame) begin
                                state_q <= ST_SEQ;
                                tdata_q <= {SEQ_HDR, seq_q};
                            end else begin
                                state_q <= ST_LEFT;
                                tdata_q <= sext(nxt_frame[FRAME_W-1:SAMPLE_WIDTH]);
                                right_q <= nxt_frame[SAMPLE_WIDTH-1:0];
                            end
`else
                            state_q <= ST_LEFT;
                            tdata_q <= sext(nxt_frame[FRAME_W-1:SAMPLE_WIDTH]);
                            right_q <= nxt_frame[SAMPLE_WIDTH-1:0];
`endif
                        end else begin
                            state_q  <= ST_IDLE;
                            tvalid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign overflow      = ovf_q;
    assign drop_count    = drop_cnt_q;

endmodule
